stream_packet_fifo: RTL
=======================

Name: stream_packet_fifo

Overview:
- Avalon-ST packet buffer placed directly downstream of the endian-swapper stage.
- Accepts that stage's stream_out_* bus (data, empty, sop, eop, valid/ready) and presents it to the sink with first-word-fall-through timing.
- Absorbs sink backpressure, reports occupancy, counts delivered packets, and flags input framing violations.
- Cut-through only: words are forwarded as soon as they are stored; the block never waits for a complete packet.

Parameters:
- DATA_BYTES, 8, bytes per beat; data width DATA_BYTES*8, empty width $clog2(DATA_BYTES).
- DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- stream_in_data  in  DATA_BYTES*8  input beat data
- stream_in_empty  in  $clog2(DATA_BYTES)  unused bytes on eop beat
- stream_in_valid  in  1  input beat valid
- stream_in_startofpacket  in  1  first beat of packet
- stream_in_endofpacket  in  1  last beat of packet
- stream_in_ready  out  1  FIFO can accept a beat
- stream_out_data  out  DATA_BYTES*8  head-of-FIFO data
- stream_out_empty  out  $clog2(DATA_BYTES)  head empty field
- stream_out_valid  out  1  FIFO non-empty
- stream_out_startofpacket  out  1  head sop
- stream_out_endofpacket  out  1  head eop
- stream_out_ready  in  1  sink accepts head
- fill_level  out  $clog2(DEPTH)+1  stored beat count, 0..DEPTH
- pkt_count  out  16  eop beats delivered, wraps 0xFFFF->0
- framing_error  out  1  sticky framing-violation flag
- framing_error_clear  in  1  clears framing_error

Behaviour:
- Reset (async assert, sync release): pointers=0, fill_level=0, stream_out_valid=0, stream_in_ready=1, pkt_count=0, framing_error=0, input FSM=IDLE. Data/empty/sop/eop outputs drive 0 while empty.
- Write: stream_in_valid & stream_in_ready. Stores {data, empty, sop, eop} at wr_ptr; wr_ptr advances modulo DEPTH.
- Read: stream_out_valid & stream_out_ready. rd_ptr advances modulo DEPTH.
- stream_in_ready = (fill_level != DEPTH), decoded from registered state only; it does not depend on stream_out_ready. A full FIFO refuses writes even when a read happens in the same cycle.
- stream_out_valid = (fill_level != 0). Output fields are the entry at rd_ptr.
- Latency: a beat written on edge N is visible at the output after edge N; minimum in-to-out latency is 1 cycle.
- fill_level: +1 on write only, -1 on read only, unchanged when both occur.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are resolved from fill_level, never from pointer equality.
- Empty field is stored and forwarded unmodified on every beat; no masking.
- Input framing FSM, updated on accepted beats only:
  - IDLE + sop & eop -> IDLE (single-beat packet).
  - IDLE + sop & !eop -> IN_PKT.
  - IDLE + !sop -> framing error; state becomes IN_PKT if !eop, else stays IDLE.
  - IN_PKT + sop -> framing error; state becomes IDLE if eop, else stays IN_PKT.
  - IN_PKT + !sop & eop -> IDLE.
  - IN_PKT + !sop & !eop -> IN_PKT.
  - Erroneous beats are still stored and forwarded; the block never drops data.
- framing_error sets on the edge after an erroneous accept and holds until framing_error_clear. If set and clear coincide, set wins.
- pkt_count increments on every read with stream_out_endofpacket=1.
- Reset mid-packet: FIFO contents are discarded and the FSM returns to IDLE. A continuation beat arriving after reset is flagged as a framing error.

Decomposition:
- Shared package stream_pkg: empty-width function/constant for DATA_BYTES, a packed beat typedef {data, empty, sop, eop}, and the framing FSM state enum {IDLE, IN_PKT}.
- One sub-module, stream_fifo_mem: DEPTH x beat-width register array with 1 write port and 1 combinational read port.
- Pointers, level, FSM, and counters stay in the top block.

Test Plan:
- Single beat: one sop+eop beat, data 0x0011223344556677, empty=3, sink ready -> output valid 1 cycle after accept with identical fields; pkt_count=1; fill_level returns to 0.
- Fill to full: sink ready=0, push 16 beats -> fill_level=16, stream_in_ready=0 on the cycle after the 16th accept; a 17th beat is held at the source and not stored.
- Full + simultaneous: FIFO full, sink ready=1, source valid -> a read occurs but no write that cycle; next cycle stream_in_ready=1 and fill_level=15.
- Streaming: 4-beat packets back-to-back with both sides always ready, 100 packets -> no bubbles after the first, fill_level steady at 1 or less, pkt_count=100, order preserved.
- Framing: send sop, sop (no eop between) -> framing_error=1 after the second accept and both beats forwarded. Pulse framing_error_clear -> 0. Send an orphan non-sop beat from IDLE -> error set again.
- Reset mid-operation: 5 beats stored, assert reset asynchronously between edges -> outputs take reset values immediately; after release, fill_level=0 and pkt_count=0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types for the stream packet FIFO: beat layout, empty-field width
// helper and the input framing FSM states.
package stream_pkg;

  localparam int DATA_BYTES_DEFAULT = 8;

  function automatic int empty_width(input int data_bytes);
    return (data_bytes > 1) ? $clog2(data_bytes) : 1;
  endfunction

  localparam int EMPTY_W_DEFAULT = empty_width(DATA_BYTES_DEFAULT);

  typedef struct packed {
    logic [DATA_BYTES_DEFAULT*8-1:0] data;
    logic [EMPTY_W_DEFAULT-1:0]      empty;
    logic                            sop;
    logic                            eop;
  } beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH register array, one synchronous write port and one
// combinational read port (gives first-word-fall-through at the top level).
module stream_fifo_mem #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents need no reset: the top masks the outputs while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_packet_fifo.sv
// Cut-through Avalon-ST packet FIFO with FWFT output, occupancy report,
// delivered-packet counter and sticky input framing-error flag.
module stream_packet_fifo
  import stream_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int DEPTH      = 16,
  localparam int DATA_W  = DATA_BYTES * 8,
  localparam int EMPTY_W = empty_width(DATA_BYTES),
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  stream_in_data,
  input  logic [EMPTY_W-1:0] stream_in_empty,
  input  logic               stream_in_valid,
  input  logic               stream_in_startofpacket,
  input  logic               stream_in_endofpacket,
  output logic               stream_in_ready,
  output logic [DATA_W-1:0]  stream_out_data,
  output logic [EMPTY_W-1:0] stream_out_empty,
  output logic               stream_out_valid,
  output logic               stream_out_startofpacket,
  output logic               stream_out_endofpacket,
  input  logic               stream_out_ready,
  output logic [LVL_W-1:0]   fill_level,
  output logic [15:0]        pkt_count,
  output logic               framing_error,
  input  logic               framing_error_clear,
  output frame_state_t       framing_state
);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready here comes from registers only.

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;
  } fifo_beat_t;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  fifo_beat_t       wr_beat, head;
  logic             wr_en, rd_en;
  frame_state_t     state_q, state_d;
  logic             err_set;

  assign stream_in_ready  = (level != LVL_W'(DEPTH));
  assign stream_out_valid = (level != '0);
  assign wr_en = stream_in_valid & stream_in_ready;
  assign rd_en = stream_out_valid & stream_out_ready;

  assign wr_beat = '{data:  stream_in_data,
                     empty: stream_in_empty,
                     sop:   stream_in_startofpacket,
                     eop:   stream_in_endofpacket};

  stream_fifo_mem #(
    .WIDTH($bits(fifo_beat_t)),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_beat),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign stream_out_data          = stream_out_valid ? head.data  : '0;
  assign stream_out_empty         = stream_out_valid ? head.empty : '0;
  assign stream_out_startofpacket = stream_out_valid & head.sop;
  assign stream_out_endofpacket   = stream_out_valid & head.eop;
  assign fill_level               = level;
  assign framing_state            = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (rd_en && head.eop) pkt_count <= pkt_count + 16'd1;
    end
  end

  // Whatever the state, eop closes the packet and !eop leaves one open;
  // only the legality of sop depends on where we are.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    if (wr_en) begin
      state_d = stream_in_endofpacket ? IDLE : IN_PKT;
      case (state_q)
        IDLE:    err_set = ~stream_in_startofpacket;
        IN_PKT:  err_set = stream_in_startofpacket;
        default: err_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      framing_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) framing_error <= 1'b1;
      else if (framing_error_clear) framing_error <= 1'b0;
    end
  end

endmodule
